// File: rtl/seg7_anim_pkg.sv
// Shared constants for the multi-digit 7-segment animation engine.
// Mode encodings, segment bit positions and fixed sequence lengths.
package seg7_anim_pkg;

    typedef enum logic [1:0] {
        MODE_FLASH  = 2'd0,
        MODE_ROTATE = 2'd1,
        MODE_SNAKE  = 2'd2,
        MODE_FIG8   = 2'd3
    } mode_e;

    localparam int SEG_A = 0;
    localparam int SEG_B = 1;
    localparam int SEG_C = 2;
    localparam int SEG_D = 3;
    localparam int SEG_E = 4;
    localparam int SEG_F = 5;
    localparam int SEG_G = 6;

    localparam int ROT_LEN  = 6;
    localparam int FIG8_LEN = 8;

    // Figure-8 path: a, b, g, e, d, c, g, f
    function automatic int fig8_seg(input int k);
        int s;
        s = SEG_A;
        case (k)
            1:       s = SEG_B;
            2:       s = SEG_G;
            3:       s = SEG_E;
            4:       s = SEG_D;
            5:       s = SEG_C;
            6:       s = SEG_G;
            7:       s = SEG_F;
            default: s = SEG_A;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/seg7_tick_gen.sv
// Base-tick prescaler and 2^speed divider producing a one-cycle step strobe.
// clr_i restarts both counters; en_i=0 freezes them.
module seg7_tick_gen
    import seg7_anim_pkg::*;
#(
    parameter int TICK_DIV = 20_000_000
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       en_i,
    input  logic       clr_i,
    input  logic [1:0] speed_i,
    output logic       step_o
);

    localparam int CNT_W = $clog2(TICK_DIV);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       sub_q, sub_d;
    logic             tick;

    always_comb begin
        tick   = en_i && (cnt_q == CNT_W'(TICK_DIV - 1));
        cnt_d  = cnt_q;
        sub_d  = sub_q;
        step_o = 1'b0;
        if (clr_i) begin
            cnt_d = '0;
            sub_d = '0;
        end else if (tick) begin
            cnt_d = '0;
            sub_d = sub_q + 3'd1;
            // Steps only ever fire on a base tick, so speed changes cannot glitch
            unique case (speed_i)
                2'd0: step_o = 1'b1;
                2'd1: step_o = sub_q[0];
                2'd2: step_o = &sub_q[1:0];
                2'd3: step_o = &sub_q[2:0];
                default: step_o = 1'b0;
            endcase
        end else if (en_i) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
            sub_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            sub_q <= sub_d;
        end
    end

endmodule

// File: rtl/seg7_anim_multi.sv
// N-digit 7-segment attract animation: flash, rotate, snake and figure-8.
// Define SEG7_ANIM_PWM_EN to add bright_i and a 16-level PWM gate on seg_o.
module seg7_anim_multi
    import seg7_anim_pkg::*;
#(
    parameter int NUM_DIGITS = 4,
    parameter int TICK_DIV   = 20_000_000
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    en_i,
    input  logic [1:0]              mode_i,
    input  logic                    dir_i,
    input  logic [1:0]              speed_i,
`ifdef SEG7_ANIM_PWM_EN
    input  logic [3:0]              bright_i,
`endif
    output logic [7*NUM_DIGITS-1:0] seg_o,
    output logic                    step_o
);

    localparam int W = 7 * NUM_DIGITS;

    function automatic logic [4:0] seq_len(input mode_e m);
        logic [4:0] l;
        unique case (m)
            MODE_FLASH:  l = 5'd2;
            MODE_ROTATE: l = 5'(ROT_LEN);
            MODE_SNAKE:  l = 5'(2 * NUM_DIGITS + 4);
            MODE_FIG8:   l = 5'(FIG8_LEN);
            default:     l = 5'd2;
        endcase
        return l;
    endfunction

    function automatic logic [W-1:0] pattern(input mode_e m,
                                             input logic [4:0] idx,
                                             input logic ph);
        logic [W-1:0] p;
        int k;
        p = '0;
        k = int'(idx);
        unique case (m)
            MODE_FLASH: p = ph ? '1 : '0;
            MODE_ROTATE: begin
                for (int d = 0; d < NUM_DIGITS; d++) p[7*d + SEG_A + k] = 1'b1;
            end
            MODE_SNAKE: begin
                // Top edge left->right, right side down, bottom right->left, left side up
                if (k < NUM_DIGITS)               p[7*k + SEG_A] = 1'b1;
                else if (k == NUM_DIGITS)         p[7*(NUM_DIGITS-1) + SEG_B] = 1'b1;
                else if (k == NUM_DIGITS + 1)     p[7*(NUM_DIGITS-1) + SEG_C] = 1'b1;
                else if (k < 2*NUM_DIGITS + 2)    p[7*(2*NUM_DIGITS+1-k) + SEG_D] = 1'b1;
                else if (k == 2*NUM_DIGITS + 2)   p[SEG_E] = 1'b1;
                else                              p[SEG_F] = 1'b1;
            end
            MODE_FIG8: begin
                for (int d = 0; d < NUM_DIGITS; d++) p[7*d + fig8_seg(k)] = 1'b1;
            end
            default: p = '0;
        endcase
        return p;
    endfunction

    mode_e        mode_q, mode_d;
    logic [4:0]   idx_q, idx_d;
    logic         phase_q, phase_d;
    logic         started_q, started_d;
    logic [W-1:0] seg_q, seg_d;
    logic         step_q, step_d;
    logic         mode_chg;
    logic         tick_step;
    logic [4:0]   len;

    assign mode_chg = (mode_i != mode_q);

    seg7_tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .en_i    (en_i),
        .clr_i   (mode_chg),
        .speed_i (speed_i),
        .step_o  (tick_step)
    );

    always_comb begin
        len       = seq_len(mode_q);
        mode_d    = mode_q;
        idx_d     = idx_q;
        phase_d   = phase_q;
        started_d = started_q;
        seg_d     = seg_q;
        step_d    = 1'b0;
        if (mode_chg) begin
            mode_d    = mode_e'(mode_i);
            idx_d     = '0;
            phase_d   = 1'b0;
            started_d = 1'b0;
            seg_d     = '0;
        end else if (tick_step) begin
            step_d = 1'b1;
            if (!started_q) begin
                started_d = 1'b1;
                idx_d     = '0;
                phase_d   = 1'b1;
            end else if (mode_q == MODE_FLASH) begin
                phase_d = ~phase_q;
            end else if (!dir_i) begin
                idx_d = (idx_q == len - 5'd1) ? 5'd0 : idx_q + 5'd1;
            end else begin
                idx_d = (idx_q == 5'd0) ? len - 5'd1 : idx_q - 5'd1;
            end
            seg_d = pattern(mode_q, idx_d, phase_d);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            mode_q    <= mode_e'(mode_i);
            idx_q     <= '0;
            phase_q   <= 1'b0;
            started_q <= 1'b0;
            seg_q     <= '0;
            step_q    <= 1'b0;
        end else begin
            mode_q    <= mode_d;
            idx_q     <= idx_d;
            phase_q   <= phase_d;
            started_q <= started_d;
            seg_q     <= seg_d;
            step_q    <= step_d;
        end
    end

    assign step_o = step_q;

`ifdef SEG7_ANIM_PWM_EN
    logic [3:0] pwm_q, pwm_d;

    // Free-running so brightness stays steady while the animation is frozen
    assign pwm_d = pwm_q + 4'd1;

    always_ff @(posedge clk_i) begin
        if (rst_i) pwm_q <= '0;
        else       pwm_q <= pwm_d;
    end

    assign seg_o = (pwm_q < bright_i) ? seg_q : '0;
`else
    assign seg_o = seg_q;
`endif

endmodule
